// File: rtl/blk_e08af3.sv
// blk_e08af3: key-protected IJTAG select controller driving a secure scan mux
//   ijtag_tck    : clock, all state changes on the rising edge
//   ijtag_reset  : asynchronous active-high reset
//   ijtag_sel    : TDR selected; ce/se/ue ignored when low
//   ijtag_ce     : capture enable (highest priority)
//   ijtag_se     : shift enable
//   ijtag_ue     : update enable (lowest priority)
//   ijtag_si     : scan in, enters sr MSB
//   ijtag_so     : scan out, sr LSB
//   mux_select   : registered select to the scan mux (state OPEN)
//   locked       : registered lockout flag (state LOCKOUT)
//   fail_count   : registered count of mismatched unlock attempts
module blk_e08af3 #(
    parameter int KEY_WIDTH = 8,
    parameter logic [KEY_WIDTH-1:0] KEY_VALUE = 8'hA5,
    parameter int MAX_FAILS = 3,
    parameter int FCNT_W = $clog2(MAX_FAILS + 1)
) (
    input  logic              ijtag_tck,
    input  logic              ijtag_reset,
    input  logic              ijtag_sel,
    input  logic              ijtag_ce,
    input  logic              ijtag_se,
    input  logic              ijtag_ue,
    input  logic              ijtag_si,
    output logic              ijtag_so,
    output logic              mux_select,
    output logic              locked,
    output logic [FCNT_W-1:0] fail_count
);
    typedef enum logic [1:0] {CLOSED, OPEN, LOCKOUT} state_t;
    state_t state, state_nx;
    logic [KEY_WIDTH:0] sr, sr_nx;
    logic [FCNT_W-1:0] fail_count_nx, fail_inc;
    assign ijtag_so = sr[0];
    assign mux_select = state == OPEN;
    assign locked = state == LOCKOUT;
    assign fail_inc = fail_count == FCNT_W'(MAX_FAILS) ? fail_count : fail_count + 1'b1;
    always_comb begin
        state_nx = state;
        fail_count_nx = fail_count;
        sr_nx = sr;
        if (ijtag_sel) begin
            if (ijtag_ce)
                // capture exposes status only; the key field reads back as zeros
                sr_nx = {mux_select, {(KEY_WIDTH-1){1'b0}}, locked};
            else if (ijtag_se)
                sr_nx = {ijtag_si, sr[KEY_WIDTH:1]};
            else if (ijtag_ue && state != LOCKOUT) begin
                if (!sr[KEY_WIDTH])
                    state_nx = CLOSED;
                else if (sr[KEY_WIDTH-1:0] == KEY_VALUE) begin
                    state_nx = OPEN;
                    fail_count_nx = '0;
                end else begin
                    fail_count_nx = fail_inc;
                    state_nx = fail_inc == FCNT_W'(MAX_FAILS) ? LOCKOUT : CLOSED;
                end
            end
        end
    end
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            state <= CLOSED;
            fail_count <= '0;
            sr <= '0;
        end else begin
            state <= state_nx;
            fail_count <= fail_count_nx;
            sr <= sr_nx;
        end
    end
endmodule

// File: tb/tb_blk_e08af3.sv
// tb_blk_e08af3: self-checking bench for blk_e08af3 against a queue-based model
module tb_blk_e08af3;
    logic ijtag_tck = 0, ijtag_reset = 1;
    logic ijtag_sel = 0, ijtag_ce = 0, ijtag_se = 0, ijtag_ue = 0, ijtag_si = 0;
    logic ijtag_so, mux_select, locked;
    logic [1:0] fail_count;
    int checks = 0, errors = 0;

    // model: sr as a bit queue, index 0 is the scan-out end
    bit m_sr[$];
    bit m_open, m_locked;
    int m_fails;

    blk_e08af3 dut (
        .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset), .ijtag_sel(ijtag_sel),
        .ijtag_ce(ijtag_ce), .ijtag_se(ijtag_se), .ijtag_ue(ijtag_ue), .ijtag_si(ijtag_si),
        .ijtag_so(ijtag_so), .mux_select(mux_select), .locked(locked), .fail_count(fail_count)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    function void model_reset();
        m_sr = {};
        for (int i = 0; i < 9; i++) m_sr.push_back(1'b0);
        m_open = 0;
        m_locked = 0;
        m_fails = 0;
    endfunction

    function void model_step(bit s, bit c, bit e, bit u, bit i);
        logic [7:0] key;
        if (!s) return;
        if (c) begin
            m_sr = {};
            m_sr.push_back(m_locked);
            for (int k = 0; k < 7; k++) m_sr.push_back(1'b0);
            m_sr.push_back(m_open);
        end else if (e) begin
            void'(m_sr.pop_front());
            m_sr.push_back(i);
        end else if (u && !m_locked) begin
            for (int k = 0; k < 8; k++) key[k] = m_sr[k];
            if (!m_sr[8]) m_open = 0;
            else if (key == 8'hA5) begin
                m_open = 1;
                m_fails = 0;
            end else begin
                m_open = 0;
                m_fails = (m_fails < 3) ? m_fails + 1 : 3;
                if (m_fails == 3) m_locked = 1;
            end
        end
    endfunction

    function logic [4:0] exp_out();
        return {m_sr[0], m_open, m_locked, 2'(m_fails)};
    endfunction

    task automatic step(input logic s, c, e, u, i);
        ijtag_sel = s; ijtag_ce = c; ijtag_se = e; ijtag_ue = u; ijtag_si = i;
        @(posedge ijtag_tck);
        model_step(s, c, e, u, i);
        #1;
    endtask

    task automatic shift_word(input logic selb, input logic [7:0] key);
        logic [8:0] w;
        w = {selb, key};
        for (int i = 0; i < 9; i++) step(1, 0, 1, 0, w[i]);
    endtask

    task automatic update();
        step(1, 0, 0, 1, 0);
    endtask

    task automatic capture_read(output logic [8:0] v);
        step(1, 1, 0, 0, 0);
        v[0] = ijtag_so;
        for (int i = 1; i < 9; i++) begin
            step(1, 0, 1, 0, 0);
            v[i] = ijtag_so;
        end
    endtask

    task automatic do_reset();
        ijtag_reset = 1;
        #2;
        model_reset();
        ijtag_reset = 0;
    endtask

    task automatic test_reset();
        logic [8:0] v;
        #3;
        checks++;
        if ({ijtag_so, mux_select, locked, fail_count} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=00000", {ijtag_so, mux_select, locked, fail_count});
        end
        #2 ijtag_reset = 0;
        model_reset();
        capture_read(v);
        checks++;
        if (v !== 9'h000) begin
            errors++; $display("FAIL reset_capture got=%h exp=000", v);
        end
        checks++;
        if ({mux_select, locked, fail_count} !== 4'b0) begin
            errors++; $display("FAIL reset_status got=%b exp=0000", {mux_select, locked, fail_count});
        end
    endtask

    task automatic test_unlock();
        logic [8:0] v;
        shift_word(1, 8'hA5);
        checks++;
        if (mux_select !== 1'b0) begin
            errors++; $display("FAIL unlock_before_ue got=%b exp=0", mux_select);
        end
        update();
        checks++;
        if ({mux_select, locked, fail_count} !== 4'b1000) begin
            errors++; $display("FAIL unlock_open got=%b exp=1000", {mux_select, locked, fail_count});
        end
        capture_read(v);
        checks++;
        if (v !== 9'h100) begin
            errors++; $display("FAIL unlock_capture got=%h exp=100", v);
        end
        shift_word(1, 8'hA5);
        update();
        checks++;
        if ({mux_select, fail_count} !== 3'b100) begin
            errors++; $display("FAIL reopen got=%b exp=100", {mux_select, fail_count});
        end
    endtask

    task automatic test_close();
        shift_word(0, 8'h00);
        update();
        checks++;
        if ({mux_select, locked, fail_count} !== 4'b0000) begin
            errors++; $display("FAIL close got=%b exp=0000", {mux_select, locked, fail_count});
        end
    endtask

    task automatic test_lockout();
        for (int k = 1; k <= 3; k++) begin
            shift_word(1, 8'h5A);
            update();
            checks++;
            if ({mux_select, locked, fail_count} !== {1'b0, k == 3, 2'(k)}) begin
                errors++; $display("FAIL lockout_fail%0d got=%b exp=%b", k, {mux_select, locked, fail_count}, {1'b0, k == 3, 2'(k)});
            end
        end
        shift_word(1, 8'hA5);
        update();
        update();
        checks++;
        if ({mux_select, locked, fail_count} !== 4'b0111) begin
            errors++; $display("FAIL lockout_hold got=%b exp=0111", {mux_select, locked, fail_count});
        end
        do_reset();
        checks++;
        if ({mux_select, locked, fail_count} !== 4'b0000) begin
            errors++; $display("FAIL lockout_async_reset got=%b exp=0000", {mux_select, locked, fail_count});
        end
    endtask

    task automatic test_back_to_back();
        shift_word(1, 8'h3C);
        update();
        update();
        checks++;
        if ({mux_select, locked, fail_count} !== 4'b0010) begin
            errors++; $display("FAIL b2b_fails got=%b exp=0010", {mux_select, locked, fail_count});
        end
        shift_word(1, 8'hA5);
        update();
        checks++;
        if ({mux_select, locked, fail_count} !== 4'b1000) begin
            errors++; $display("FAIL b2b_clear got=%b exp=1000", {mux_select, locked, fail_count});
        end
    endtask

    task automatic test_priority();
        logic [8:0] v;
        shift_word(0, 8'h00);
        update();
        shift_word(1, 8'hA5);
        step(1, 1, 1, 1, 1);
        checks++;
        if ({ijtag_so, mux_select} !== 2'b00) begin
            errors++; $display("FAIL prio_capture got=%b exp=00", {ijtag_so, mux_select});
        end
        update();
        checks++;
        if (mux_select !== 1'b0) begin
            errors++; $display("FAIL prio_sr_overwritten got=%b exp=0", mux_select);
        end
        shift_word(1, 8'hA5);
        for (int i = 0; i < 6; i++) step(0, 1'($urandom), 1, 1, 1'($urandom));
        checks++;
        if ({ijtag_so, mux_select} !== 2'b10) begin
            errors++; $display("FAIL sel0_hold got=%b exp=10", {ijtag_so, mux_select});
        end
        update();
        checks++;
        if (mux_select !== 1'b1) begin
            errors++; $display("FAIL sel0_sr_kept got=%b exp=1", mux_select);
        end
        capture_read(v);
        checks++;
        if (v !== 9'h100) begin
            errors++; $display("FAIL sel0_capture got=%h exp=100", v);
        end
    endtask

    task automatic test_reset_midshift();
        logic [8:0] w;
        w = {1'b1, 8'hA5};
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, w[i]);
        do_reset();
        update();
        checks++;
        if ({ijtag_so, mux_select, locked, fail_count} !== 5'b0) begin
            errors++; $display("FAIL midshift_reset got=%b exp=00000", {ijtag_so, mux_select, locked, fail_count});
        end
    endtask

    task automatic test_random();
        logic [8:0] v;
        logic [7:0] key;
        int op;
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 9);
            if (op < 5) begin
                key = $urandom_range(0, 1) ? 8'hA5 : 8'($urandom);
                shift_word(1'($urandom_range(0, 3) != 0), key);
            end else if (op < 7) capture_read(v);
            else if (op == 7) begin
                for (int i = 0; i < 3; i++) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end else if (m_locked) do_reset();
            checks++;
            if ({ijtag_so, mux_select, locked, fail_count} !== exp_out()) begin
                errors++; $display("FAIL rand_pre%0d got=%b exp=%b", n, {ijtag_so, mux_select, locked, fail_count}, exp_out());
            end
            update();
            checks++;
            if ({ijtag_so, mux_select, locked, fail_count} !== exp_out()) begin
                errors++; $display("FAIL rand_ue%0d got=%b exp=%b", n, {ijtag_so, mux_select, locked, fail_count}, exp_out());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_unlock();
        test_close();
        test_lockout();
        test_back_to_back();
        test_priority();
        test_reset_midshift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/blk_e08af3.md
Name: firebird7_in_gate2_tessent_scanmux_secure_select_ctrl

Overview:
- IJTAG-accessible, key-protected select controller that drives mux_select of a secure scan mux.
- Implements a test data register (TDR) of {select bit, key}.
- The mux is switched to its secondary input only when a matching key is shifted in with the update.
- Repeated wrong keys latch a lockout state that forces mux_select=0 until reset.

Parameters:
- KEY_WIDTH, 8, width of unlock key field; legal range 2 to 64.
- KEY_VALUE, 8'hA5, unlock key compared on update; width KEY_WIDTH.
- MAX_FAILS, 3, number of mismatched updates that cause lockout; must be at least 1.
- FCNT_W, $clog2(MAX_FAILS+1), width of the fail counter (derived).

Ports:
- ijtag_tck  input  1  single clock; all state changes on the rising edge.
- ijtag_reset  input  1  asynchronous, active-high reset.
- ijtag_sel  input  1  TDR selected; ce/se/ue are ignored when 0.
- ijtag_ce  input  1  capture enable.
- ijtag_se  input  1  shift enable.
- ijtag_ue  input  1  update enable.
- ijtag_si  input  1  scan in.
- ijtag_so  output  1  scan out; equals sr[0].
- mux_select  output  1  registered select to the scan mux.
- locked  output  1  registered lockout flag.
- fail_count  output  FCNT_W  registered count of mismatched unlock attempts.

Behaviour:
- Shift register: sr[KEY_WIDTH:0]. sr[KEY_WIDTH] is the select bit; sr[KEY_WIDTH-1:0] is the key field.
- Reset: asynchronous, takes effect immediately regardless of clock.
  - sr=0, mux_select=0, locked=0, fail_count=0, state=CLOSED, ijtag_so=0.
  - Reset mid-shift discards the partial content.
- States: CLOSED (mux_select=0), OPEN (mux_select=1), LOCKOUT (mux_select=0, locked=1). mux_select and locked are decoded from registered state; no combinational path from inputs.
- Per rising edge with ijtag_sel=1, priority ce > se > ue:
  - ce: sr <= {mux_select, (KEY_WIDTH-1) zeros, locked}. The key is never readable.
  - se (ce=0): sr <= {ijtag_si, sr[KEY_WIDTH:1]}. si enters the MSB; so is the LSB, with 1-cycle latency per bit.
  - ue (ce=0, se=0): evaluated on the current sr:
    - LOCKOUT: no change to any state or counter.
    - sr[KEY_WIDTH]=0: state -> CLOSED. No key check; fail_count unchanged.
    - sr[KEY_WIDTH]=1 and key field == KEY_VALUE: state -> OPEN, fail_count <= 0.
    - sr[KEY_WIDTH]=1 and key mismatch: state -> CLOSED, fail_count <= fail_count+1. If the new value equals MAX_FAILS, state -> LOCKOUT.
  - sr is unchanged by ue.
- ijtag_sel=0: sr and all state hold. Inputs ce/se/ue/si are don't-care.
- mux_select changes exactly one cycle after the ue edge. Back-to-back ue cycles are each evaluated on the same sr.
- fail_count saturates at MAX_FAILS; it never wraps.
- Only ijtag_reset leaves LOCKOUT.
- OPEN -> OPEN with the correct key again: no change, fail_count stays 0.

Test Plan (KEY_WIDTH=8, KEY_VALUE=8'hA5, MAX_FAILS=3):
- Reset, then capture and shift 9 bits out -> so sequence (LSB first) 0,0,0,0,0,0,0,0,0; mux_select=0, locked=0, fail_count=0.
- Shift {1,8'hA5} (9 se cycles, LSB first), then 1 ue cycle -> mux_select=1 on the next cycle, fail_count=0. Capture and shift -> so bit0=0, bit8=1.
- From OPEN, shift {0,8'h00} then ue -> mux_select=0, fail_count=0 (closing needs no key).
- Three updates of {1,8'h5A} -> fail_count 1,2,3; locked=1 after the third. A subsequent {1,8'hA5} update -> mux_select remains 0, fail_count=3. Assert ijtag_reset -> locked=0, fail_count=0 asynchronously.
- Same cycle ce=1, se=1, ue=1 with sr={1,8'hA5} -> capture only; mux_select unchanged. With ijtag_sel=0 and se/ue toggled -> sr and mux_select hold.
- Assert ijtag_reset after 4 of 9 shift cycles of {1,8'hA5}, then release and apply ue -> mux_select=0, state CLOSED, fail_count=0 (sr was cleared, so the select bit is 0).
